// File: rtl/fft_output_buffer_pkg.sv
// Shared constants and FSM state type for the FFT output buffer.
package fft_output_buffer_pkg;

    localparam int SIZE        = 16;
    localparam int OUTPUT_SIZE = 512;
    localparam int SAMPLES     = 2048;
    localparam int WORDS       = SAMPLES * SIZE / OUTPUT_SIZE;
    localparam int LANES       = OUTPUT_SIZE / SIZE;
    localparam int IDX_W       = $clog2(WORDS);
    localparam int CNT_W       = $clog2(SAMPLES);
    localparam int LANE_W      = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DONE
    } fsm_state_e;

endpackage

// File: rtl/output_word_mem.sv
// Packed-word storage: one synchronous write port and one synchronous read port.
// A read of the word being written returns its previous contents.
module output_word_mem
    import fft_output_buffer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [IDX_W-1:0]       waddr,
    input  logic [OUTPUT_SIZE-1:0] wdata,
    input  logic [IDX_W-1:0]       raddr,
    output logic [OUTPUT_SIZE-1:0] rdata
);

    logic [OUTPUT_SIZE-1:0] mem_q [WORDS];
    logic [OUTPUT_SIZE-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Only the read register is reset; the array itself keeps its contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fft_output_buffer.sv
// Collects a frame of serial samples into packed 512-bit words for wide readout.
//
//   state   | meaning
//   IDLE    | waiting for start, samples rejected (flag overflow)
//   CAPTURE | accepting samples, committing each full word
//   DONE    | full frame stored, waiting for next start
module fft_output_buffer
    import fft_output_buffer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   sample_valid,
    input  logic [SIZE-1:0]        sample_in,
    input  logic [IDX_W-1:0]       output_index,
    output logic [OUTPUT_SIZE-1:0] data_out,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow
);

    fsm_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [OUTPUT_SIZE-1:0] asm_q, asm_d;
    logic                   ovf_q, ovf_d;
    logic                   accept;
    logic                   commit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            asm_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        ovf_d   = ovf_q;
        accept  = 1'b0;
        // start wins over everything, including a sample in the same cycle
        if (start) begin
            state_d = CAPTURE;
            cnt_d   = '0;
            asm_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                CAPTURE: begin
                    if (sample_valid) begin
                        accept = 1'b1;
                        asm_d[cnt_q[LANE_W-1:0]*SIZE +: SIZE] = sample_in;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(SAMPLES - 1)) begin
                            state_d = DONE;
                        end
                    end
                end
                default: begin
                    if (sample_valid) begin
                        ovf_d = 1'b1;
                    end
                end
            endcase
        end
    end

    // asm_d already holds this cycle's sample in lane 31 when the word commits.
    assign commit = accept && (cnt_q[LANE_W-1:0] == '1);

    output_word_mem u_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (commit),
        .waddr (cnt_q[CNT_W-1:LANE_W]),
        .wdata (asm_d),
        .raddr (output_index),
        .rdata (data_out)
    );

    assign busy     = (state_q == CAPTURE);
    assign done     = (state_q == DONE);
    assign overflow = ovf_q;

endmodule

// File: doc/fft_output_buffer.md
FFT_OUTPUT_BUFFER -- requirements
Module: fft_output_buffer

Interface
REQ-001 Parameters SHALL be, one per line:
  SIZE  16  bits per sample
  OUTPUT_SIZE  512  bits per packed output word
  SAMPLES  2048  samples per frame
REQ-002 Derived constants SHALL be WORDS = SAMPLES*SIZE/OUTPUT_SIZE (64) and LANES = OUTPUT_SIZE/SIZE (32).
REQ-003 Ports SHALL be, one per line:
  clk  in  1  single clock, all logic on rising edge
  rst_n  in  1  reset, asynchronous, active-low
  start  in  1  begin capture of a new frame
  sample_valid  in  1  sample_in carries a sample this cycle
  sample_in  in  SIZE  serial sample, real part of processed spectrum/wave
  output_index  in  $clog2(WORDS)  packed word to read (STE)
  data_out  out  OUTPUT_SIZE  packed word, registered
  busy  out  1  capture in progress
  done  out  1  full frame captured, level
  overflow  out  1  sticky, sample arrived while not capturing

Function
REQ-004 FSM states SHALL be IDLE, CAPTURE and DONE.
REQ-005 IDLE: start -> CAPTURE; sample_valid ignored.
REQ-006 CAPTURE: each cycle with sample_valid SHALL accept one sample and increment an 11-bit sample counter.
REQ-007 Sample k SHALL land in word k/LANES, bits [16*(k%LANES)+15 : 16*(k%LANES)]; the earliest sample occupies the lowest lane.
REQ-008 Accepted samples SHALL be written into a 512-bit assembly register by lane.
REQ-009 On acceptance of lane 31, the assembled word, including that cycle's sample, SHALL be committed to word memory at index counter[10:5] on the following edge.
REQ-010 Acceptance of sample 2047 SHALL move CAPTURE -> DONE, set done and clear busy on the same edge; counter wraps to 0.
REQ-011 DONE: state held until start; start -> CAPTURE and clears done.
REQ-012 busy SHALL be 1 exactly while in CAPTURE.
REQ-013 start during CAPTURE SHALL restart: counter and assembly register cleared, any sample_valid that cycle dropped, already-committed words left intact.
REQ-014 sample_valid in IDLE or DONE SHALL set overflow, with start in the same cycle taking priority (no overflow, sample dropped); overflow is cleared only by start or reset.
REQ-015 Reads: data_out SHALL equal memory[output_index] one cycle after output_index is presented, in every state.
REQ-016 Read-during-commit to the same word SHALL return the old contents; the new word is visible the cycle after.
REQ-017 The last word SHALL be readable on the first cycle done is observed high.
REQ-018 sample_valid gaps in CAPTURE SHALL stall the counter without loss.

Reset
REQ-019 While rst_n is low: state = IDLE; counter = 0; assembly register = 0; data_out = 0; busy = 0; done = 0; overflow = 0.
REQ-020 Word memory contents SHALL NOT be reset.
REQ-021 Reset asserted mid-capture SHALL abandon the frame immediately; no commit occurs on the reset edge.

Structure
REQ-022 SIZE, OUTPUT_SIZE, SAMPLES, WORDS, LANES and the FSM state enum SHALL live in the shared audio package.
REQ-023 Storage SHALL be one sub-module, output_word_mem: 64 x 512, one synchronous write port, one synchronous read port with old-data read-during-write, no reset.

Verification
REQ-024 Bench SHALL cover the following directed scenarios:
  - Full frame: start, then 2048 back-to-back samples value k -> done high after last; word 0 lanes = 0..31, word 63 lane 31 = 2047; busy low.
  - Gapped input: sample_valid every 3rd cycle, 2048 samples -> same memory image as full frame; done only after the 2048th sample.
  - Restart: start, 100 samples, start, 2048 samples of 0xA5A5 -> all 64 words all-0xA5A5; overflow 0.
  - Overflow: sample_valid while in DONE -> overflow 1, memory unchanged; next start -> overflow 0.
  - Read hazard: read word 1 in the cycle sample 63 is accepted -> old word 1 returned; read again next cycle -> new word 1.
  - Reset mid-capture: rst_n low after 500 samples -> outputs all 0, state IDLE; sample_valid without start sets overflow, memory unchanged.
